// File: rtl/sccpu_pkg.sv
// Shared encodings and helpers for the single-cycle RV32I-subset computer.
package sccpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_JALR    = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef enum logic [1:0] {NPC_PLUS4, NPC_BRANCH, NPC_JAL, NPC_JALR} npc_sel_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_t;

  function automatic logic [31:0] alu_eval(alu_op_t op, logic [31:0] a, logic [31:0] b);
    logic [31:0] res;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = a << b[4:0];
      ALU_SRL:  res = a >> b[4:0];
      ALU_SRA:  res = 32'($signed(a) >>> b[4:0]);
      ALU_SLT:  res = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: res = {31'b0, a < b};
      default:  res = a + b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sc_comp_im.sv
// Instruction ROM: word array filled externally, combinational read.
module im #(
  parameter int IM_DEPTH = 128
) (
  input  logic [$clog2(IM_DEPTH)-1:0] i_idx,
  output logic [31:0]                 o_instr
);

  logic [31:0] ROM [0:IM_DEPTH-1];

  assign o_instr = ROM[i_idx];

endmodule

// File: rtl/sc_comp.sv
// Single-cycle RV32I-subset computer: one instruction retired per clock.
module sc_comp
  import sccpu_pkg::*;
#(
  parameter int IM_DEPTH = 128,
  parameter int DM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);

  localparam int IAW = $clog2(IM_DEPTH);
  localparam int DAW = $clog2(DM_DEPTH);

  logic [31:0] PC;
  logic [31:0] instr;
  logic [31:0] r_rf [0:31];
  logic [31:0] r_dm [0:DM_DEPTH-1];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1_idx;
  logic [4:0]  w_rs2_idx;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm;
  logic [31:0] w_rs1;
  logic [31:0] w_rs2;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu;
  logic [31:0] w_pc4;
  logic [31:0] w_pc_next;
  logic [31:0] w_dm_rdata;
  logic [31:0] w_wb;
  logic        w_b_imm;
  logic        w_rf_we;
  logic        w_mem_we;
  alu_op_t     w_alu_op;
  npc_sel_t    w_npc_sel;
  wb_sel_t     w_wb_sel;

  im #(.IM_DEPTH(IM_DEPTH)) U_IM (
    .i_idx   (PC[IAW+1:2]),
    .o_instr (instr)
  );

  assign w_opcode  = instr[6:0];
  assign w_rd      = instr[11:7];
  assign w_funct3  = instr[14:12];
  assign w_rs1_idx = instr[19:15];
  assign w_rs2_idx = instr[24:20];
  assign w_funct7  = instr[31:25];

  assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_u = {instr[31:12], 12'h000};
  assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign w_rs1    = (w_rs1_idx == '0) ? '0 : r_rf[w_rs1_idx];
  assign w_rs2    = (w_rs2_idx == '0) ? '0 : r_rf[w_rs2_idx];
  assign reg_data = (reg_sel == '0) ? '0 : r_rf[reg_sel];

  assign w_alu_b    = w_b_imm ? w_imm : w_rs2;
  assign w_alu      = alu_eval(w_alu_op, w_rs1, w_alu_b);
  assign w_pc4      = PC + 32'd4;
  assign w_dm_rdata = r_dm[w_alu[DAW+1:2]];

  // Decode: anything not explicitly recognised leaves all write enables low (NOP)
  always_comb begin
    w_alu_op  = ALU_ADD;
    w_b_imm   = 1'b0;
    w_imm     = w_imm_i;
    w_rf_we   = 1'b0;
    w_mem_we  = 1'b0;
    w_npc_sel = NPC_PLUS4;
    w_wb_sel  = WB_ALU;
    case (w_opcode)
      OP_R: begin
        w_rf_we = 1'b1;
        case ({w_funct7, w_funct3})
          {F7_BASE, F3_ADD_SUB}: w_alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD_SUB}: w_alu_op = ALU_SUB;
          {F7_BASE, F3_SLL}:     w_alu_op = ALU_SLL;
          {F7_BASE, F3_SLT}:     w_alu_op = ALU_SLT;
          {F7_BASE, F3_SLTU}:    w_alu_op = ALU_SLTU;
          {F7_BASE, F3_XOR}:     w_alu_op = ALU_XOR;
          {F7_BASE, F3_SRL_SRA}: w_alu_op = ALU_SRL;
          {F7_ALT,  F3_SRL_SRA}: w_alu_op = ALU_SRA;
          {F7_BASE, F3_OR}:      w_alu_op = ALU_OR;
          {F7_BASE, F3_AND}:     w_alu_op = ALU_AND;
          default:               w_rf_we  = 1'b0;
        endcase
      end
      OP_I: begin
        w_rf_we = 1'b1;
        w_b_imm = 1'b1;
        case (w_funct3)
          F3_ADD_SUB: w_alu_op = ALU_ADD;
          F3_SLT:     w_alu_op = ALU_SLT;
          F3_SLTU:    w_alu_op = ALU_SLTU;
          F3_XOR:     w_alu_op = ALU_XOR;
          F3_OR:      w_alu_op = ALU_OR;
          F3_AND:     w_alu_op = ALU_AND;
          F3_SLL: begin
            if (w_funct7 == F7_BASE) w_alu_op = ALU_SLL;
            else                     w_rf_we  = 1'b0;
          end
          F3_SRL_SRA: begin
            if (w_funct7 == F7_BASE)     w_alu_op = ALU_SRL;
            else if (w_funct7 == F7_ALT) w_alu_op = ALU_SRA;
            else                         w_rf_we  = 1'b0;
          end
          default: w_rf_we = 1'b0;
        endcase
      end
      OP_LOAD: begin
        if (w_funct3 == F3_LW) begin
          w_rf_we  = 1'b1;
          w_b_imm  = 1'b1;
          w_wb_sel = WB_MEM;
        end
      end
      OP_STORE: begin
        if (w_funct3 == F3_SW) begin
          w_mem_we = 1'b1;
          w_b_imm  = 1'b1;
          w_imm    = w_imm_s;
        end
      end
      OP_BRANCH: begin
        if (((w_funct3 == F3_BEQ) && (w_rs1 == w_rs2)) ||
            ((w_funct3 == F3_BNE) && (w_rs1 != w_rs2)))
          w_npc_sel = NPC_BRANCH;
      end
      OP_LUI: begin
        w_rf_we  = 1'b1;
        w_wb_sel = WB_IMM;
        w_imm    = w_imm_u;
      end
      OP_JAL: begin
        w_rf_we   = 1'b1;
        w_wb_sel  = WB_PC4;
        w_npc_sel = NPC_JAL;
      end
      OP_JALR: begin
        if (w_funct3 == F3_JALR) begin
          w_rf_we   = 1'b1;
          w_b_imm   = 1'b1;
          w_wb_sel  = WB_PC4;
          w_npc_sel = NPC_JALR;
        end
      end
      default: ;
    endcase
  end

  // Write-back source select
  always_comb begin
    w_wb = w_alu;
    case (w_wb_sel)
      WB_ALU: w_wb = w_alu;
      WB_MEM: w_wb = w_dm_rdata;
      WB_PC4: w_wb = w_pc4;
      WB_IMM: w_wb = w_imm;
      default: w_wb = w_alu;
    endcase
  end

  // Next-PC select
  always_comb begin
    w_pc_next = w_pc4;
    case (w_npc_sel)
      NPC_PLUS4:  w_pc_next = w_pc4;
      NPC_BRANCH: w_pc_next = PC + w_imm_b;
      NPC_JAL:    w_pc_next = PC + w_imm_j;
      NPC_JALR:   w_pc_next = {w_alu[31:1], 1'b0};
      default:    w_pc_next = w_pc4;
    endcase
  end

  // Program counter
  always_ff @(posedge clk) begin
    if (!rstn) PC <= '0;
    else       PC <= w_pc_next;
  end

  // Register file: cleared on reset, x0 never written
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_rf_we && (w_rd != '0)) begin
      r_rf[w_rd] <= w_wb;
    end
  end

  // Data RAM: contents survive reset, but no store commits during a reset edge
  always_ff @(posedge clk) begin
    if (rstn && w_mem_we) r_dm[w_alu[DAW+1:2]] <= w_rs2;
  end

endmodule

// File: tb/tb_sc_comp.sv
// Bench for sc_comp: directed programs plus random programs against an ISA-level model.
module tb_sc_comp;

  localparam int IM = 128;
  localparam int DM = 128;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  reg_sel = '0;
  logic [31:0] reg_data;

  sc_comp #(.IM_DEPTH(IM), .DM_DEPTH(DM)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
  );

  always #50 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] rom_img [IM];
  logic [31:0] m_x     [32];
  logic [31:0] m_mem   [DM];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic load(input logic [31:0] prog [$]);
    for (int i = 0; i < IM; i++) begin
      rom_img[i] = (i < prog.size()) ? prog[i] : 32'h00000013;
      dut.U_IM.ROM[i] = rom_img[i];
    end
  endtask

  function automatic int didx(input logic [31:0] ad);
    return int'((ad >> 2) % 32'(DM));
  endfunction

  // ISA-level interpreter of one instruction
  task automatic m_step();
    logic [31:0] ins, a, b, iI, iS, iB, iJ, iU, res, nxt;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wr;
    ins = rom_img[int'((m_pc >> 2) % 32'(IM))];
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
    a  = m_x[ins[19:15]];
    b  = m_x[ins[24:20]];
    iI = {{20{ins[31]}}, ins[31:20]};
    iS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    iB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    iU = {ins[31:12], 12'h000};
    res = '0; wr = 1'b0; nxt = m_pc + 32'd4;
    case (op)
      7'h33: begin
        wr = 1'b1;
        case ({f7, f3})
          10'h000: res = a + b;
          10'h100: res = a - b;
          10'h001: res = a << b[4:0];
          10'h002: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          10'h003: res = (a < b) ? 32'd1 : 32'd0;
          10'h004: res = a ^ b;
          10'h005: res = a >> b[4:0];
          10'h105: res = 32'($signed(a) >>> b[4:0]);
          10'h006: res = a | b;
          10'h007: res = a & b;
          default: wr = 1'b0;
        endcase
      end
      7'h13: begin
        wr = 1'b1;
        case (f3)
          3'd0: res = a + iI;
          3'd2: res = ($signed(a) < $signed(iI)) ? 32'd1 : 32'd0;
          3'd3: res = (a < iI) ? 32'd1 : 32'd0;
          3'd4: res = a ^ iI;
          3'd6: res = a | iI;
          3'd7: res = a & iI;
          3'd1: if (f7 == 7'h00) res = a << iI[4:0]; else wr = 1'b0;
          default: begin
            if (f7 == 7'h00)      res = a >> iI[4:0];
            else if (f7 == 7'h20) res = 32'($signed(a) >>> iI[4:0]);
            else                  wr = 1'b0;
          end
        endcase
      end
      7'h03: if (f3 == 3'd2) begin wr = 1'b1; res = m_mem[didx(a + iI)]; end
      7'h23: if (f3 == 3'd2) m_mem[didx(a + iS)] = b;
      7'h63: if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b)) nxt = m_pc + iB;
      7'h37: begin wr = 1'b1; res = iU; end
      7'h6F: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + iJ; end
      7'h67: if (f3 == 3'd0) begin wr = 1'b1; res = m_pc + 32'd4; nxt = (a + iI) & ~32'd1; end
      default: ;
    endcase
    if (wr && rd != 5'd0) m_x[rd] = res;
    m_pc = nxt;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    m_pc = '0;
    for (int i = 0; i < 32; i++) m_x[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    m_step();
  endtask

  task automatic chk_const(input string tag, input int idx, input logic [31:0] exp);
    reg_sel = 5'(idx); #1;
    check(tag, reg_data, exp);
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      reg_sel = 5'(i); #1;
      check($sformatf("%s_x%0d", tag, i), reg_data, m_x[i]);
    end
  endtask

  function automatic logic [31:0] gen_rand();
    int unsigned k;
    logic [4:0]  rd, rs1, rs2, bs1, bs2;
    logic [31:0] r;
    logic [11:0] imm;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [12:0] bo;
    logic [20:0] jo;
    k   = $urandom_range(0, 9);
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    bs1 = 5'($urandom_range(0, 3));
    bs2 = 5'($urandom_range(0, 3));
    r   = $urandom();
    case (k)
      0: begin
        f7 = r[19] ? 7'h20 : 7'h00;
        if (r[22:21] == 2'd0) f7 = r[31:25];
        return {f7, rs2, rs1, r[2:0], rd, 7'h33};
      end
      1, 2: begin
        f3  = r[2:0];
        imm = r[14:3];
        if (f3 == 3'd1 || f3 == 3'd5) begin
          imm[11:5] = r[15] ? 7'h20 : 7'h00;
          if (r[17:16] == 2'd0) imm[11:5] = r[31:25];
        end
        return {imm, rs1, f3, rd, 7'h13};
      end
      3: return {r[31:12], rd, 7'h37};
      4: begin
        imm = 12'($urandom_range(0, 63)) - 12'd32;
        return {imm, 5'd0, 3'd2, rd, 7'h03};
      end
      5: begin
        imm = 12'($urandom_range(0, 63)) - 12'd32;
        return {imm[11:5], rs2, 5'd0, 3'd2, imm[4:0], 7'h23};
      end
      6: begin
        bo = 13'(4 * $urandom_range(1, 8));
        f3 = r[0] ? 3'd1 : 3'd0;
        if (r[3:1] == 3'd0) f3 = r[6:4];
        return {bo[12], bo[10:5], bs2, bs1, f3, bo[4:1], bo[11], 7'h63};
      end
      7: begin
        jo = 21'(4 * $urandom_range(1, 16));
        return {jo[20], jo[10:1], jo[11], jo[19:12], rd, 7'h6F};
      end
      8: return {r[31:20], rs1, (r[5:4] == 2'd0) ? r[14:12] : 3'd0, rd, 7'h67};
      default: return r;
    endcase
  endfunction

  initial begin
    logic [31:0] q [$];
    logic [11:0] o;

    // Reset state, then addi/add through the debug port
    q = {32'h00500393, 32'h007384B3};
    load(q);
    do_reset();
    check("rst_pc", dut.PC, 32'h0);
    check("rst_instr", dut.instr, 32'h00500393);
    chk_const("rst_x7", 7, 32'h0);
    tick();
    check("pc_after_1", dut.PC, 32'h4);
    chk_const("addi_x7", 7, 32'd5);
    tick();
    chk_const("add_x9", 9, 32'd10);

    // Store then load through data RAM
    q = {32'h00500393, 32'h00702223, 32'h00402403};
    load(q);
    do_reset();
    tick(); tick(); tick();
    chk_const("lw_x8", 8, 32'd5);

    // x0 stays zero
    q = {32'h00900013};
    load(q);
    do_reset();
    tick();
    check("x0_pc", dut.PC, 32'h4);
    chk_const("x0_keep", 0, 32'h0);

    // Taken / not-taken branches
    q = {32'h00000463};
    load(q);
    do_reset();
    tick();
    check("beq_taken", dut.PC, 32'h8);
    q = {32'h00001463};
    load(q);
    do_reset();
    tick();
    check("bne_not_taken", dut.PC, 32'h4);

    // jal x1,+16 at PC 0x8
    q = {32'h00000013, 32'h00000013, 32'h010000EF};
    load(q);
    do_reset();
    tick(); tick(); tick();
    check("jal_pc", dut.PC, 32'h18);
    chk_const("jal_link", 1, 32'hC);

    // Unrecognised word behaves as a NOP
    q = {32'h00500393, 32'hFFFFFFFF};
    load(q);
    do_reset();
    tick(); tick();
    check("nop_pc", dut.PC, 32'h8);
    chk_const("nop_x7", 7, 32'd5);
    chk_all("nop");

    // Reset mid-run aborts the instruction at 0x10 and the program replays
    q = {32'h00100093, 32'h00208113, 32'h002081B3, 32'hFFF18213, 32'h00720293};
    load(q);
    do_reset();
    tick(); tick(); tick(); tick();
    check("mid_pc_before", dut.PC, 32'h10);
    chk_const("mid_x4_before", 4, 32'd3);
    do_reset();
    check("mid_pc_reset", dut.PC, 32'h0);
    chk_all("mid_cleared");
    for (int i = 0; i < 5; i++) tick();
    check("mid_pc_replay", dut.PC, 32'h14);
    chk_const("mid_x1", 1, 32'd1);
    chk_const("mid_x2", 2, 32'd3);
    chk_const("mid_x3", 3, 32'd4);
    chk_const("mid_x4", 4, 32'd3);
    chk_const("mid_x5", 5, 32'd10);

    // Random programs: prefix zeroes the RAM window reached by x0-relative loads
    for (int p = 0; p < 2; p++) begin
      q = {};
      for (int i = 0; i < 8; i++) begin
        o = 12'(4 * i);
        q.push_back({o[11:5], 5'd0, 5'd0, 3'd2, o[4:0], 7'h23});
        o = 12'(-4 * (i + 1));
        q.push_back({o[11:5], 5'd0, 5'd0, 3'd2, o[4:0], 7'h23});
      end
      for (int i = 0; i < 100; i++) q.push_back(gen_rand());
      load(q);
      do_reset();
      for (int c = 0; c < 200; c++) begin
        tick();
        check($sformatf("rnd%0d_pc_c%0d", p, c), dut.PC, m_pc);
        check($sformatf("rnd%0d_instr_c%0d", p, c), dut.instr,
              rom_img[int'((m_pc >> 2) % 32'(IM))]);
        reg_sel = 5'($urandom_range(0, 31)); #1;
        check($sformatf("rnd%0d_x%0d_c%0d", p, reg_sel, c), reg_data, m_x[reg_sel]);
      end
      chk_all($sformatf("rnd%0d_end", p));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
